// File: rtl/pipe_run_controller.sv
// ---------------------------------------------------------------------------
// pipe_run_controller
//   Execution controller for the 5-stage MIPS pipeline. Generates the global
//   stage enable (o_pipe_enabled) from debug commands: free-run, run-N-cycles,
//   single-step and run-to-breakpoint. A decoded HALT drains the pipeline for
//   N_STAGES-1 cycles and then parks the controller in HALTED. A saturating
//   enabled-cycle counter and a stop-reason register are exposed for debug.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_cmd_valid/i_cmd   command strobe and code (RUN, STEP, RUN_N, STOP, CLEAR)
//   i_cmd_arg           cycle count for RUN_N
//   i_bp_wr_*           breakpoint slot write port (index, address, enable)
//   i_fetch_pc          PC of the instruction about to be fetched
//   i_halt_decoded      HALT opcode present in decode
//   o_pipe_enabled      global stage enable
//   o_cmd_ready         command accept
//   o_cmd_error         one-cycle pulse when a command is ignored
//   o_state             controller state (IDLE, RUN, RUN_N, DRAIN, HALTED)
//   o_stop_reason       NONE, USER, BP, COUNT, HALT
//   o_bp_hit_idx        lowest matching slot at the last breakpoint stop
//   o_cycle_count       saturating count of enabled cycles
// ---------------------------------------------------------------------------
module pipe_run_controller #(
  parameter int NB_PC         = 32,
  parameter int NB_CYCLE      = 32,
  parameter int N_BREAKPOINTS = 4,
  parameter int N_STAGES      = 5,
  localparam int NB_BP_IDX    = (N_BREAKPOINTS > 1) ? $clog2(N_BREAKPOINTS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  input  logic [2:0]           i_cmd,
  input  logic [NB_CYCLE-1:0]  i_cmd_arg,
  input  logic                 i_bp_wr_en,
  input  logic [NB_BP_IDX-1:0] i_bp_wr_idx,
  input  logic [NB_PC-1:0]     i_bp_wr_addr,
  input  logic                 i_bp_wr_valid,
  input  logic [NB_PC-1:0]     i_fetch_pc,
  input  logic                 i_halt_decoded,
  output logic                 o_pipe_enabled,
  output logic                 o_cmd_ready,
  output logic                 o_cmd_error,
  output logic [2:0]           o_state,
  output logic [2:0]           o_stop_reason,
  output logic [NB_BP_IDX-1:0] o_bp_hit_idx,
  output logic [NB_CYCLE-1:0]  o_cycle_count
);

  localparam int NB_DRAIN = $clog2(N_STAGES + 1);

  localparam logic [2:0] CMD_RUN   = 3'd0;
  localparam logic [2:0] CMD_STEP  = 3'd1;
  localparam logic [2:0] CMD_RUN_N = 3'd2;
  localparam logic [2:0] CMD_STOP  = 3'd3;
  localparam logic [2:0] CMD_CLEAR = 3'd4;

  localparam logic [2:0] REASON_NONE  = 3'd0;
  localparam logic [2:0] REASON_USER  = 3'd1;
  localparam logic [2:0] REASON_BP    = 3'd2;
  localparam logic [2:0] REASON_COUNT = 3'd3;
  localparam logic [2:0] REASON_HALT  = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StRunN   = 3'd2,
    StDrain  = 3'd3,
    StHalted = 3'd4
  } ctrlState_e;

  ctrlState_e           stateReg, stateNext;
  logic [NB_CYCLE-1:0]  countReg, countNext;
  logic [NB_DRAIN-1:0]  drainReg, drainNext;
  logic                 skipReg, skipNext;
  logic [2:0]           reasonReg, reasonNext;
  logic [NB_BP_IDX-1:0] bpHitReg, bpHitNext;
  logic                 errorReg, errorNext;
  logic [NB_CYCLE-1:0]  cycleReg;
  logic                 clearCycles;

  logic [NB_PC-1:0]         bpAddrReg  [N_BREAKPOINTS];
  logic [N_BREAKPOINTS-1:0] bpValidReg;
  logic [N_BREAKPOINTS-1:0] slotHit;
  logic                     bpMatch;
  logic [NB_BP_IDX-1:0]     bpHitIdxNow;

  logic cmdReady, cmdAccept, running, stopCmd, stopNow, pipeEn;

  // Breakpoint slots: writable in any state, visible to the matcher next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_BREAKPOINTS; gi++) begin : gBpSlot
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          bpAddrReg[gi]  <= '0;
          bpValidReg[gi] <= 1'b0;
        end else if (i_bp_wr_en && (i_bp_wr_idx == NB_BP_IDX'(gi))) begin
          bpAddrReg[gi]  <= i_bp_wr_addr;
          bpValidReg[gi] <= i_bp_wr_valid;
        end
      end
      assign slotHit[gi] = bpValidReg[gi] && (bpAddrReg[gi] == i_fetch_pc);
    end
  endgenerate

  assign bpMatch = |slotHit;

  // Scan from the top down so the lowest matching slot wins.
  always_comb begin
    bpHitIdxNow = '0;
    for (int i = N_BREAKPOINTS - 1; i >= 0; i--) begin
      if (slotHit[i]) bpHitIdxNow = NB_BP_IDX'(i);
    end
  end

  assign cmdReady  = (stateReg == StIdle) || (stateReg == StRun) ||
                     (stateReg == StRunN) || (stateReg == StHalted);
  assign cmdAccept = i_cmd_valid && cmdReady;
  assign running   = (stateReg == StRun) || (stateReg == StRunN);
  assign stopCmd   = running && cmdAccept && (i_cmd == CMD_STOP);
  // The skip flag masks the breakpoint on the first enabled cycle so a resume
  // from a breakpoint PC does not immediately re-hit it.
  assign stopNow   = running && ((bpMatch && !skipReg) || stopCmd);
  // Combinational so a breakpoint instruction is never fetched and STOP bites
  // in the cycle it is accepted.
  assign pipeEn    = (running || (stateReg == StDrain)) && !stopNow;

  always_comb begin
    stateNext   = stateReg;
    countNext   = countReg;
    drainNext   = drainReg;
    skipNext    = skipReg;
    reasonNext  = reasonReg;
    bpHitNext   = bpHitReg;
    errorNext   = 1'b0;
    clearCycles = 1'b0;

    if (pipeEn) skipNext = 1'b0;

    case (stateReg)
      StIdle: begin
        if (cmdAccept) begin
          case (i_cmd)
            CMD_RUN: begin
              stateNext  = StRun;
              skipNext   = 1'b1;
              reasonNext = REASON_NONE;
            end
            CMD_STEP: begin
              stateNext  = StRunN;
              countNext  = NB_CYCLE'(1);
              skipNext   = 1'b1;
              reasonNext = REASON_NONE;
            end
            CMD_RUN_N: begin
              if (i_cmd_arg != '0) begin
                stateNext  = StRunN;
                countNext  = i_cmd_arg;
                skipNext   = 1'b1;
                reasonNext = REASON_NONE;
              end else begin
                errorNext = 1'b1;
              end
            end
            CMD_STOP: ;
            CMD_CLEAR: begin
              clearCycles = 1'b1;
              reasonNext  = REASON_NONE;
            end
            default: errorNext = 1'b1;
          endcase
        end
      end

      StRun, StRunN: begin
        // Only STOP is meaningful while running.
        if (cmdAccept && (i_cmd != CMD_STOP)) errorNext = 1'b1;

        // Same-cycle priority: HALT > BP > COUNT > USER.
        if (i_halt_decoded) begin
          reasonNext = REASON_HALT;
          if (N_STAGES > 1) begin
            stateNext = StDrain;
            drainNext = NB_DRAIN'(N_STAGES - 1);
          end else begin
            stateNext = StHalted;
          end
        end else if (bpMatch && !skipReg) begin
          stateNext  = StIdle;
          reasonNext = REASON_BP;
          bpHitNext  = bpHitIdxNow;
        end else if ((stateReg == StRunN) && (countReg == NB_CYCLE'(1))) begin
          stateNext  = StIdle;
          reasonNext = REASON_COUNT;
        end else if (stopCmd) begin
          stateNext  = StIdle;
          reasonNext = REASON_USER;
        end else if ((stateReg == StRunN) && pipeEn) begin
          countNext = countReg - NB_CYCLE'(1);
        end
      end

      StDrain: begin
        if (drainReg <= NB_DRAIN'(1)) begin
          stateNext = StHalted;
          drainNext = '0;
        end else begin
          drainNext = drainReg - NB_DRAIN'(1);
        end
      end

      StHalted: begin
        if (cmdAccept) begin
          if (i_cmd == CMD_CLEAR) begin
            stateNext   = StIdle;
            clearCycles = 1'b1;
            reasonNext  = REASON_NONE;
          end else begin
            errorNext = 1'b1;
          end
        end
      end

      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stateReg  <= StIdle;
      countReg  <= '0;
      drainReg  <= '0;
      skipReg   <= 1'b0;
      reasonReg <= REASON_NONE;
      bpHitReg  <= '0;
      errorReg  <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      countReg  <= countNext;
      drainReg  <= drainNext;
      skipReg   <= skipNext;
      reasonReg <= reasonNext;
      bpHitReg  <= bpHitNext;
      errorReg  <= errorNext;
    end
  end

  // Saturating enabled-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cycleReg <= '0;
    end else if (clearCycles) begin
      cycleReg <= '0;
    end else if (pipeEn && (cycleReg != '1)) begin
      cycleReg <= cycleReg + NB_CYCLE'(1);
    end
  end

  assign o_pipe_enabled = pipeEn;
  assign o_cmd_ready    = cmdReady;
  assign o_cmd_error    = errorReg;
  assign o_state        = stateReg;
  assign o_stop_reason  = reasonReg;
  assign o_bp_hit_idx   = bpHitReg;
  assign o_cycle_count  = cycleReg;

endmodule

// File: tb/tb_pipe_run_controller.sv
// ---------------------------------------------------------------------------
// tb_pipe_run_controller
//   Directed self-checking bench for pipe_run_controller. A second instance
//   with a 4-bit cycle counter shares all inputs and is used for the
//   saturation check. Inputs are driven 1 ns after the rising edge; outputs
//   are tallied on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_run_controller;

  localparam logic [2:0] RUN = 3'd0, STEP = 3'd1, RUNN = 3'd2, STOP = 3'd3, CLEAR = 3'd4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd;
  logic [31:0] i_cmd_arg;
  logic        i_bp_wr_en;
  logic [1:0]  i_bp_wr_idx;
  logic [31:0] i_bp_wr_addr;
  logic        i_bp_wr_valid;
  logic [31:0] i_fetch_pc;
  logic        i_halt_decoded;

  logic        o_pipe_enabled, o_cmd_ready, o_cmd_error;
  logic [2:0]  o_state, o_stop_reason;
  logic [1:0]  o_bp_hit_idx;
  logic [31:0] o_cycle_count;

  logic        smallEnabled, smallReady, smallError;
  logic [2:0]  smallState, smallReason;
  logic [1:0]  smallHitIdx;
  logic [3:0]  smallCount;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int enTally    = 0;
  int errTally   = 0;
  bit autoPc     = 1'b0;

  always #5 i_clk = ~i_clk;

  pipe_run_controller dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_cmd_arg(i_cmd_arg), .i_bp_wr_en(i_bp_wr_en), .i_bp_wr_idx(i_bp_wr_idx),
    .i_bp_wr_addr(i_bp_wr_addr), .i_bp_wr_valid(i_bp_wr_valid),
    .i_fetch_pc(i_fetch_pc), .i_halt_decoded(i_halt_decoded),
    .o_pipe_enabled(o_pipe_enabled), .o_cmd_ready(o_cmd_ready),
    .o_cmd_error(o_cmd_error), .o_state(o_state), .o_stop_reason(o_stop_reason),
    .o_bp_hit_idx(o_bp_hit_idx), .o_cycle_count(o_cycle_count)
  );

  pipe_run_controller #(.NB_CYCLE(4)) dutSmall (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_cmd_arg(i_cmd_arg[3:0]), .i_bp_wr_en(i_bp_wr_en), .i_bp_wr_idx(i_bp_wr_idx),
    .i_bp_wr_addr(i_bp_wr_addr), .i_bp_wr_valid(i_bp_wr_valid),
    .i_fetch_pc(i_fetch_pc), .i_halt_decoded(i_halt_decoded),
    .o_pipe_enabled(smallEnabled), .o_cmd_ready(smallReady),
    .o_cmd_error(smallError), .o_state(smallState), .o_stop_reason(smallReason),
    .o_bp_hit_idx(smallHitIdx), .o_cycle_count(smallCount)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: tally outputs at the falling edge, then advance past the
  // rising edge. The fetch PC models a simple sequential program.
  task automatic cyc();
    bit adv;
    adv = 1'b0;
    @(negedge i_clk);
    if (o_pipe_enabled) begin
      enTally++;
      adv = 1'b1;
    end
    if (o_cmd_error) errTally++;
    @(posedge i_clk);
    #1;
    if (adv && autoPc) i_fetch_pc = i_fetch_pc + 32'd4;
  endtask

  task automatic sendCmd(input logic [2:0] cmd, input logic [31:0] arg);
    i_cmd_valid = 1'b1;
    i_cmd       = cmd;
    i_cmd_arg   = arg;
    cyc();
    i_cmd_valid = 1'b0;
    $display("cmd=%0d arg=%0d state=%0d reason=%0d count=%0d", cmd, arg, o_state, o_stop_reason, o_cycle_count);
  endtask

  task automatic writeBp(input logic [1:0] idx, input logic [31:0] addr);
    i_bp_wr_en    = 1'b1;
    i_bp_wr_idx   = idx;
    i_bp_wr_addr  = addr;
    i_bp_wr_valid = 1'b1;
    cyc();
    i_bp_wr_en    = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = 3'd0; i_cmd_arg = '0;
    i_bp_wr_en = 1'b0; i_bp_wr_idx = '0; i_bp_wr_addr = '0; i_bp_wr_valid = 1'b0;
    i_fetch_pc = '0; i_halt_decoded = 1'b0;

    // ---- reset state
    cyc(); cyc();
    check("rst_en", o_pipe_enabled, 0);
    check("rst_state", o_state, 0);
    check("rst_ready", o_cmd_ready, 1);
    i_rst = 1'b0;
    cyc();
    check("rst_reason", o_stop_reason, 0);
    check("rst_err", o_cmd_error, 0);
    check("rst_count", o_cycle_count, 0);

    // ---- RUN_N 7
    enTally = 0;
    sendCmd(RUNN, 32'd7);
    repeat (12) cyc();
    check("runn_en_cycles", enTally, 7);
    check("runn_state", o_state, 0);
    check("runn_reason", o_stop_reason, 3);
    check("runn_count", o_cycle_count, 7);

    // ---- breakpoint at 0x10 in slot 2
    sendCmd(CLEAR, 0);
    writeBp(2'd2, 32'h10);
    i_fetch_pc = 32'h0; autoPc = 1'b1;
    sendCmd(RUN, 0);
    repeat (8) cyc();
    check("bp_reason", o_stop_reason, 2);
    check("bp_idx", o_bp_hit_idx, 2);
    check("bp_count", o_cycle_count, 4);
    check("bp_pc", i_fetch_pc, 32'h10);
    check("bp_state", o_state, 0);
    // resume past the breakpoint PC
    sendCmd(RUN, 0);
    repeat (3) cyc();
    check("skip_state", o_state, 1);
    check("skip_pc", i_fetch_pc, 32'h1C);
    sendCmd(STOP, 0);
    cyc();
    check("user_reason", o_stop_reason, 1);
    check("user_state", o_state, 0);
    check("user_count", o_cycle_count, 7);

    // ---- two slots on the same PC: lowest index reported
    writeBp(2'd1, 32'h20);
    writeBp(2'd3, 32'h20);
    sendCmd(RUN, 0);
    repeat (3) cyc();
    check("dual_idx", o_bp_hit_idx, 1);
    check("dual_reason", o_stop_reason, 2);
    check("dual_pc", i_fetch_pc, 32'h20);
    // BP and STOP in the same cycle: BP wins
    autoPc = 1'b0; i_fetch_pc = 32'h100;
    sendCmd(RUN, 0);
    cyc(); cyc();
    check("run_reason_cleared", o_stop_reason, 0);
    check("run_state", o_state, 1);
    i_fetch_pc = 32'h20; i_cmd_valid = 1'b1; i_cmd = STOP;
    #1;
    check("bpstop_en", o_pipe_enabled, 0);
    cyc();
    i_cmd_valid = 1'b0;
    cyc();
    check("bpstop_reason", o_stop_reason, 2);
    check("bpstop_idx", o_bp_hit_idx, 1);

    // ---- HALT and drain
    i_fetch_pc = 32'h200;
    sendCmd(CLEAR, 0);
    enTally = 0;
    sendCmd(RUN, 0);
    repeat (4) cyc();
    i_halt_decoded = 1'b1;
    cyc();
    i_halt_decoded = 1'b0;
    check("drain_state", o_state, 3);
    check("drain_ready", o_cmd_ready, 0);
    repeat (10) cyc();
    check("halt_en_cycles", enTally, 9);
    check("halt_state", o_state, 4);
    check("halt_reason", o_stop_reason, 4);
    check("halt_count", o_cycle_count, 9);
    check("halt_ready", o_cmd_ready, 1);
    errTally = 0;
    sendCmd(RUN, 0);
    cyc();
    check("halt_run_err", errTally, 1);
    check("halt_run_state", o_state, 4);
    sendCmd(CLEAR, 0);
    check("clear_state", o_state, 0);
    check("clear_count", o_cycle_count, 0);
    check("clear_reason", o_stop_reason, 0);

    // ---- error commands
    errTally = 0; enTally = 0;
    sendCmd(RUNN, 32'd0);
    sendCmd(3'd6, 0);
    cyc();
    check("idle_errs", errTally, 2);
    check("idle_no_en", enTally, 0);
    check("idle_state", o_state, 0);
    sendCmd(RUN, 0);
    cyc(); cyc();
    errTally = 0;
    sendCmd(STEP, 0);
    cyc(); cyc();
    check("step_in_run_err", errTally, 1);
    check("step_in_run_state", o_state, 1);
    sendCmd(STOP, 0);

    // ---- reset mid RUN_N
    i_fetch_pc = 32'h300;
    sendCmd(RUNN, 32'd100);
    repeat (10) cyc();
    check("midrun_en", o_pipe_enabled, 1);
    i_rst = 1'b1;
    #1;
    check("arst_en", o_pipe_enabled, 0);
    check("arst_state", o_state, 0);
    check("arst_ready", o_cmd_ready, 1);
    check("arst_reason", o_stop_reason, 0);
    check("arst_idx", o_bp_hit_idx, 0);
    check("arst_count", o_cycle_count, 0);
    check("arst_err", o_cmd_error, 0);
    cyc();
    i_rst = 1'b0;
    i_fetch_pc = 32'h20;
    enTally = 0;
    sendCmd(RUN, 0);
    repeat (3) cyc();
    check("bp_cleared_en", enTally, 3);
    check("bp_cleared_state", o_state, 1);
    sendCmd(STOP, 0);

    // ---- saturation on the 4-bit instance
    sendCmd(CLEAR, 0);
    sendCmd(RUN, 0);
    repeat (20) cyc();
    check("sat_small", smallCount, 15);
    check("sat_big", o_cycle_count, 20);
    sendCmd(STOP, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
